// File: rtl/eth_frame_tx.sv
// eth_frame_tx: octet-serial Ethernet-style frame transmitter.
// Sends preamble, SFD, destination MAC, source MAC, payload length, payload
// and a 4-octet LRC FCS, one octet per clock. Payload octets are pulled
// through a valid/ready handshake.
// Optional feature: define ETH_TX_IFG_EN to stretch the inter-frame gap to
// max(IFG_CYCLES, 2) cycles; without it the gap is fixed at 2 cycles.
module eth_frame_tx #(
    parameter logic [47:0] SRC_MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] req_len,
    input  logic [47:0] req_dst,
    output logic        rdy,
    input  logic [7:0]  pl_data,
    input  logic        pl_vld,
    output logic        pl_rdy,
    output logic [7:0]  data,
    output logic        start,
    output logic        active,
    output logic        done,
    output logic        err
);

`ifdef ETH_TX_IFG_EN
    localparam bit IFG_EN = 1'b1;
`else
    localparam bit IFG_EN = 1'b0;
`endif

    // The receiver needs two idle cycles after the last FCS octet before it
    // can take the next start, so the gap never drops below 2.
    localparam int unsigned GAP_LEN  = (IFG_EN && IFG_CYCLES > 2) ? IFG_CYCLES : 2;
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DST,
        S_SRC,
        S_LEN,
        S_PAY,
        S_FCS,
        S_GAP
    } state_e;

    // state_q / cnt_q always describe the octet currently shown on data.
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic [47:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  data_q, data_d;
    logic        start_q, start_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        accept;
    logic [7:0]  fcs;

    function automatic logic [7:0] mac_octet(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            3'd5:    return mac[7:0];
            default: return 8'h00;
        endcase
    endfunction

    assign rdy    = (state_q == S_IDLE);
    assign accept = (state_q == S_IDLE) && (state_d == S_PRE);
    assign fcs    = ~sum_q + 8'd1;

    assign data   = data_q;
    assign start  = start_q;
    assign active = active_q;
    assign done   = done_q;
    assign err    = err_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance through the frame sections by octet count.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req && req_len != 16'd0) state_d = S_PRE;
            S_PRE:  if (cnt_q == 16'd6) state_d = S_SFD;
            S_SFD:  state_d = S_DST;
            S_DST:  if (cnt_q == 16'd5) state_d = S_SRC;
            S_SRC:  if (cnt_q == 16'd5) state_d = S_LEN;
            S_LEN:  if (cnt_q == 16'd1) state_d = S_PAY;
            S_PAY:  if (cnt_q == len_q - 16'd1) state_d = S_FCS;
            S_FCS:  if (cnt_q == 16'd3) state_d = S_GAP;
            S_GAP:  if (cnt_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? 16'd0 : cnt_q + 16'd1;
    end

    // Outputs: choose the octet for the next slot and update checksum/flags.
    always_comb begin
        pl_rdy     = !rst && (state_d == S_PAY);
        data_d     = 8'h00;
        sum_d      = sum_q;
        underrun_d = underrun_q;
        dst_d      = dst_q;
        len_d      = len_q;
        case (state_d)
            S_PRE: data_d = 8'hAA;
            S_SFD: data_d = 8'hAB;
            S_DST: data_d = mac_octet(dst_q, cnt_d[2:0]);
            S_SRC: data_d = mac_octet(SRC_MAC_ADDR, cnt_d[2:0]);
            S_LEN: data_d = cnt_d[0] ? len_q[7:0] : len_q[15:8];
            S_PAY: begin
                // A missing octet goes out as 0x00 and poisons the FCS.
                if (pl_vld) data_d = pl_data;
                else        underrun_d = 1'b1;
            end
            S_FCS: data_d = underrun_q ? ~fcs : fcs;
            default: data_d = 8'h00;
        endcase
        if (state_d inside {S_DST, S_SRC, S_LEN, S_PAY}) sum_d = sum_q + data_d;
        if (accept) begin
            dst_d      = req_dst;
            len_d      = req_len;
            sum_d      = 8'h00;
            underrun_d = 1'b0;
        end
        start_d  = accept;
        active_d = state_d inside {S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PAY, S_FCS};
        done_d   = (state_q == S_FCS) && (state_d == S_GAP);
        err_d    = done_d && underrun_q;
    end

    // Datapath and registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q      <= 48'h0;
            len_q      <= 16'h0;
            sum_q      <= 8'h00;
            underrun_q <= 1'b0;
            data_q     <= 8'h00;
            start_q    <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dst_q      <= dst_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            underrun_q <= underrun_d;
            data_q     <= data_d;
            start_q    <= start_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed testbench for eth_frame_tx. Expected frames are hand-computed
// octet tables; define ETH_TX_IFG_EN when building with the long gap.
module tb_eth_frame_tx;

`ifdef ETH_TX_IFG_EN
    localparam int GAP = 12;
`else
    localparam int GAP = 2;
`endif
    localparam logic [47:0] DST    = 48'h00_0a_95_9d_68_16;
    localparam int          NSLOTS = 29;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] req_len;
    logic [47:0] req_dst;
    logic        rdy;
    logic [7:0]  pl_data;
    logic        pl_vld;
    logic        pl_rdy;
    logic [7:0]  data;
    logic        start;
    logic        active;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_idx = -1;
    int pl_idx;

    logic [7:0] nom [NSLOTS];
    logic [7:0] und [NSLOTS];
    logic [7:0] payload [3];

    eth_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .req_dst (req_dst),
        .rdy     (rdy),
        .pl_data (pl_data),
        .pl_vld  (pl_vld),
        .pl_rdy  (pl_rdy),
        .data    (data),
        .start   (start),
        .active  (active),
        .done    (done),
        .err     (err)
    );

    initial forever #5 clk = ~clk;

    // Upstream payload source: offers the next octet whenever pl_rdy is high,
    // withholding valid for the slot index in drop_idx.
    initial begin
        pl_idx  = 0;
        pl_vld  = 1'b1;
        pl_data = 8'hEE;
        forever begin
            @(negedge clk);
            if (start) pl_idx = 0;
            if (pl_rdy) begin
                pl_data = payload[pl_idx % 3];
                pl_vld  = (pl_idx != drop_idx);
                pl_idx++;
            end else begin
                pl_data = 8'hEE;
                pl_vld  = 1'b1;
            end
        end
    end

    task automatic wait_rdy(input string tag);
        int waited = 0;
        while (rdy !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_rdy_wait: rdy=%b after %0d cycles, required 1", tag, rdy, waited);
        end
    endtask

    task automatic run_frame(input bit underrun, input bit mid_req, input string tag);
        logic [7:0] exp_data;
        logic       exp_start, exp_plrdy;
        wait_rdy(tag);
        drop_idx = underrun ? 1 : -1;
        req      = 1'b1;
        req_len  = 16'd3;
        req_dst  = DST;
        @(negedge clk);
        req = 1'b0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (s > 0) @(negedge clk);
            exp_data  = underrun ? und[s] : nom[s];
            exp_start = (s == 0);
            exp_plrdy = (s >= 21 && s <= 23);
            n_cmp++;
            if (data !== exp_data || active !== 1'b1 || start !== exp_start ||
                pl_rdy !== exp_plrdy || done !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_slot%0d: data=%h act=%b start=%b pl_rdy=%b done=%b err=%b, required data=%h act=1 start=%b pl_rdy=%b done=0 err=0",
                         tag, s, data, active, start, pl_rdy, done, err, exp_data, exp_start, exp_plrdy);
            end
            if (mid_req && s == 10) begin
                req     = 1'b1;
                req_len = 16'd5;
                req_dst = 48'hFFFF_FFFF_FFFF;
            end
            if (mid_req && s == 14) req = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err, active, start, data} !== {1'b1, underrun, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL %s_done: done=%b err=%b act=%b start=%b data=%h, required done=1 err=%b act=0 start=0 data=00",
                     tag, done, err, active, start, data, underrun);
        end
        for (int g = 1; g < GAP; g++) begin
            @(negedge clk);
            n_cmp++;
            if ({rdy, done, err, start} !== 4'b0000) begin
                n_bad++;
                $display("FAIL %s_gap%0d: rdy=%b done=%b err=%b start=%b, required all 0", tag, g, rdy, done, err, start);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rdy !== 1'b1 || start !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_back_idle: rdy=%b start=%b, required rdy=1 start=0", tag, rdy, start);
        end
        drop_idx = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rdy, data, start, active, done, err, pl_rdy} !== {1'b1, 8'h00, 5'b00000}) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b data=%h start=%b act=%b done=%b err=%b pl_rdy=%b, required rdy=1 data=00 others 0",
                     rdy, data, start, active, done, err, pl_rdy);
        end
    endtask

    task automatic test_nominal();
        run_frame(1'b0, 1'b0, "nominal");
    endtask

    task automatic test_underrun();
        run_frame(1'b1, 1'b0, "underrun");
    endtask

    task automatic test_ignored_len0();
        wait_rdy("len0");
        req     = 1'b1;
        req_len = 16'd0;
        req_dst = DST;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rdy, start, active} !== 3'b100) begin
                n_bad++;
                $display("FAIL len0_cycle%0d: rdy=%b start=%b act=%b, required rdy=1 start=0 act=0", c, rdy, start, active);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_mid_req();
        run_frame(1'b0, 1'b1, "mid_req");
    endtask

    task automatic test_back_to_back();
        int t0 = -1;
        int t1 = -1;
        wait_rdy("b2b");
        req     = 1'b1;
        req_len = 16'd3;
        req_dst = DST;
        for (int c = 0; c < 200 && t1 < 0; c++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                if (t0 < 0) t0 = c;
                else        t1 = c;
            end
        end
        req = 1'b0;
        n_cmp++;
        if (t1 < 0 || (t1 - t0) != 30 + GAP) begin
            n_bad++;
            $display("FAIL b2b_spacing: starts at %0d and %0d, spacing %0d, required %0d", t0, t1, t1 - t0, 30 + GAP);
        end
        wait_rdy("b2b_end");
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        wait_rdy("rst_mid");
        req     = 1'b1;
        req_len = 16'd3;
        req_dst = DST;
        @(negedge clk);
        req = 1'b0;
        repeat (23) @(negedge clk);
        n_cmp++;
        if (data !== 8'h02 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_slot23: data=%h act=%b, required data=02 act=1", data, active);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({active, rdy, data, start, done, err, pl_rdy} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
            n_bad++;
            $display("FAIL rst_mid_abort: act=%b rdy=%b data=%h start=%b done=%b err=%b pl_rdy=%b, required act=0 rdy=1 data=00 others 0",
                     active, rdy, data, start, done, err, pl_rdy);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1 || start === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin
            n_bad++;
            $display("FAIL rst_mid_no_done: %0d done/start pulses after abort, required 0", n_done);
        end
        run_frame(1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        nom = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAB,
                8'h00, 8'h0a, 8'h95, 8'h9d, 8'h68, 8'h16,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h03,
                8'h01, 8'h02, 8'h03,
                8'h3A, 8'h3A, 8'h3A, 8'h3A};
        und = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAB,
                8'h00, 8'h0a, 8'h95, 8'h9d, 8'h68, 8'h16,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h03,
                8'h01, 8'h00, 8'h03,
                8'hC3, 8'hC3, 8'hC3, 8'hC3};
        payload = '{8'h01, 8'h02, 8'h03};
        rst     = 1'b1;
        req     = 1'b0;
        req_len = 16'd0;
        req_dst = 48'h0;

        test_reset();
        test_nominal();
        test_underrun();
        test_ignored_len0();
        test_mid_req();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_frame_tx.md
# eth_frame_tx

Octet-serial Ethernet-style frame transmitter, the sending end of the team's frame receiver. It frames a caller-supplied payload as preamble, SFD, destination MAC, source MAC, payload length, payload and a 4-octet LRC FCS. It drives one octet per clock on a stream that connects directly to the receiver's `data`/`start` inputs. Payload is pulled from an upstream source through a valid/ready handshake.

## Interface
Parameters:
- `SRC_MAC_ADDR`, default 48'h02_00_00_00_00_01: source MAC, sent MSB octet first.
- `IFG_CYCLES`, default 12: inter-frame gap length. Used only when `ETH_TX_IFG_EN` is defined; values below 2 are treated as 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  frame request; accepted when `rdy && req && req_len != 0`.
- `req_len`  in  16  payload length N in octets; latched on accept.
- `req_dst`  in  48  destination MAC; latched on accept.
- `rdy`  out  1  idle, able to accept `req`.
- `pl_data`  in  8  payload octet.
- `pl_vld`  in  1  `pl_data` valid.
- `pl_rdy`  out  1  transmitter takes `pl_data` this cycle.
- `data`  out  8  registered octet stream to the receiver.
- `start`  out  1  registered; one-cycle pulse coincident with the first preamble octet.
- `active`  out  1  registered; `data` carries a frame octet.
- `done`  out  1  one-cycle pulse, the cycle after the last FCS octet.
- `err`  out  1  pulses together with `done` if a payload underrun occurred in the frame.

## Operation
- States: IDLE → PREAMBLE (7) → SFD (1) → DST (6) → SRC (6) → LEN (2) → PAYLOAD (N) → FCS (4) → GAP → IDLE. Numbers in parentheses are octet counts.
- A 16-bit state counter clears on every state change.
- Frame slots, s = 0..25+N:
  - s = 0–6: 0xAA.
  - s = 7: 0xAB.
  - s = 8–13: `req_dst[47:40]` first.
  - s = 14–19: `SRC_MAC_ADDR`, MSB octet first.
  - s = 20–21: N, high octet first.
  - s = 22..21+N: payload.
  - s = 22+N..25+N: FCS.
- Checksum: 8-bit running sum, mod 256, of slots 8..21+N. FCS octet = (~sum)+1, sent 4 times identically.
- `pl_rdy` is asserted in the cycle before each payload slot. The octet is captured at that edge and appears on `data` in the next cycle.
- Underrun: if `pl_vld` is low while `pl_rdy` is high:
  - the slot carries 0x00, which is included in the sum;
  - a sticky underrun flag is set;
  - all 4 FCS octets are sent bitwise-inverted, (~((~sum)+1)), so the receiver flags ERROR;
  - `err` pulses with `done`.
- `req` is ignored when not in IDLE or when `req_len == 0`. In the `req_len == 0` case `rdy` stays high.
- `rdy` is a decode of IDLE. When not `active`, `data` = 0x00.
- `done` pulses in the first GAP cycle. GAP lasts G cycles, then the block returns to IDLE.
- G = 2 without the macro. This is the minimum the receiver needs (FCS check → SUCCESS → IDLE) before the next `start`.

## Timing
- Request accepted at edge ending cycle t: slot s is on `data` at cycle t+1+s. `start` = 1 at t+1 only.
- `active` is high for cycles t+1..t+26+N.
- Last FCS octet at L = t+26+N. `done`/`err` at L+1. GAP covers L+1..L+G. `rdy` = 1 at L+G+1.
- With `req` held high, start-to-start spacing = 27+N+G cycles.
- Reset values: `data` 0x00; `start`, `active`, `done`, `err`, `pl_rdy` 0; `rdy` 1 in the first cycle after `rst` falls.
- `rst` mid-frame aborts immediately: the next cycle shows reset values, no `done` is generated, and the checksum and underrun flag clear.

## Configuration
- `ETH_TX_IFG_EN` defined: G = max(`IFG_CYCLES`, 2); with the default, G = 12.
- Not defined: G = 2 and `IFG_CYCLES` is ignored.

## Test plan
- Reset: hold `rst` for 3 cycles, then release → `rdy`=1, `data`=0x00, and `start`, `active`, `done`, `err`, `pl_rdy` all 0.
- Nominal frame: `req_dst`=00_0a_95_9d_68_16, N=3, payload 01 02 03, `pl_vld` held 1 → `data` = AA×7, AB, 00 0a 95 9d 68 16, 02 00 00 00 00 01, 00 03, 01 02 03, 3A×4. `start` at t+1, `done`=1 and `err`=0 at t+30. The receiver with matching DEST reaches SUCCESS.
- Underrun: same frame with `pl_vld`=0 in the cycle before slot 23 → slot 23 = 0x00, FCS = C3×4, `err`=`done`=1 at t+30. The receiver reports ERROR.
- Ignored requests: `req` with `req_len`=0 → no `start`, `rdy` stays 1. `req` mid-frame → the frame is unaffected and only one `start` occurs.
- Back-to-back: `req` held high, N=3 → starts spaced 32 cycles without the macro, 42 with `ETH_TX_IFG_EN`.
- Reset during PAYLOAD slot 1 → next cycle `active`=0, `rdy`=1, no `done`. A following nominal frame is bit-exact with the nominal-frame case above.
